// File: rtl/prime_window_stats.sv
// Windowed statistics over the prime detector stream.
// Emits one count/max report per WINDOW samples or per flush.
module prime_window_stats #(
    parameter int WINDOW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_prime,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_count,
    output logic [7:0] out_samples,
    output logic [3:0] out_max,
    output logic       out_any
);

    localparam logic [7:0] WIN    = 8'(WINDOW);
    localparam logic [7:0] WIN_M1 = 8'(WINDOW - 1);

    logic [7:0] sample_cnt;
    logic [7:0] hit_cnt;
    logic [3:0] max_acc;
    logic       flush_pend;

    logic       slot_free;
    logic       take;
    logic [7:0] eff_cnt;
    logic [7:0] eff_hit;
    logic [3:0] eff_max;
    logic       close_full;
    logic       close_flush;
    logic       close;
    logic       flush_nxt;

    always_comb begin
        slot_free = !out_valid || out_ready;
        // A held report blocks the sample that would need to close a window.
        in_ready  = !(!slot_free &&
                      (sample_cnt == WIN_M1 ||
                       (flush_pend && sample_cnt != 8'd0)));
        take      = in_valid && in_ready;

        eff_cnt = sample_cnt;
        eff_hit = hit_cnt;
        eff_max = max_acc;
        if (take) begin
            eff_cnt = sample_cnt + 8'd1;
            if (in_prime) begin
                eff_hit = hit_cnt + 8'd1;
                if (in_data > max_acc) begin
                    eff_max = in_data;
                end
            end
        end

        close_full  = take && (eff_cnt == WIN);
        close_flush = flush_pend && (eff_cnt != 8'd0) && slot_free;
        close       = close_full || close_flush;
        flush_nxt   = flush ||
                      (flush_pend && !close && eff_cnt != 8'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt  <= 8'd0;
            hit_cnt     <= 8'd0;
            max_acc     <= 4'd0;
            flush_pend  <= 1'b0;
            out_valid   <= 1'b0;
            out_count   <= 8'd0;
            out_samples <= 8'd0;
            out_max     <= 4'd0;
            out_any     <= 1'b0;
        end else begin
            flush_pend <= flush_nxt;
            if (close) begin
                sample_cnt  <= 8'd0;
                hit_cnt     <= 8'd0;
                max_acc     <= 4'd0;
                out_valid   <= 1'b1;
                out_count   <= eff_hit;
                out_samples <= eff_cnt;
                out_max     <= eff_max;
                out_any     <= (eff_hit != 8'd0);
            end else begin
                sample_cnt <= eff_cnt;
                hit_cnt    <= eff_hit;
                max_acc    <= eff_max;
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
